// File: rtl/sram_lane_seq.sv
// rtl/sram_lane_seq.sv - valid/ready request sequencer driving LANES shared-address SRAM macros
module sram_lane_seq #(
  parameter int ADDR_W    = 11,
  parameter int LANES     = 4,
  parameter int LANE_W    = 8,
  parameter int WR_CYC    = 1,
  parameter int SENSE_CYC = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LANES*LANE_W-1:0]   req_wdata,
  input  logic [LANES-1:0]          req_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LANES*LANE_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [LANES*LANE_W-1:0]   sram_din,
  output logic [LANES-1:0]          sram_write_en,
  output logic                      sram_sense_en,
  input  logic [LANES*LANE_W-1:0]   sram_dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_RECOV = 3'd2;
  localparam logic [2:0] S_SENSE = 3'd3;
  localparam logic [2:0] S_CAPT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [3:0] WR_LOAD    = 4'(WR_CYC - 1);
  localparam logic [3:0] SENSE_LOAD = 4'(SENSE_CYC - 1);

  logic [2:0]       state;
  logic [3:0]       cnt;
  logic [LANES-1:0] be_reg;
  logic             accept;

  // Strobes decode straight from state so they can never overlap.
  assign req_ready     = (state == S_IDLE);
  assign accept        = req_valid && req_ready;
  assign sram_write_en = (state == S_WRITE) ? be_reg : '0;
  assign sram_sense_en = (state != S_SENSE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      be_reg    <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sram_addr <= req_addr;
            sram_din  <= req_wdata;
            be_reg    <= req_be;
            if (!req_we) begin
              state <= S_SENSE;
              cnt   <= SENSE_LOAD;
            end else if (req_be != '0) begin
              state <= S_WRITE;
              cnt   <= WR_LOAD;
            end
          end
        end
        S_WRITE: begin
          if (cnt == 4'd0) begin
            state <= S_RECOV;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // One idle cycle keeps address/data stable past the write_en falling edge.
        S_RECOV: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        S_SENSE: begin
          if (cnt == 4'd0) begin
            state <= S_CAPT;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_CAPT: begin
          rsp_rdata <= sram_dout;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
          cnt       <= '0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lane_seq.sv
// tb/tb_sram_lane_seq.sv - bench for sram_lane_seq: default instance vs cycle model, wide-pulse instance vs scoreboard
module tb_sram_lane_seq;

  localparam int WC1 = 1;
  localparam int SC1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int          checks = 0;
  int          failures = 0;

  // Instance 1: defaults (ADDR_W=11, LANES=4, LANE_W=8, WR_CYC=1, SENSE_CYC=1)
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, sram_sense_en;
  logic [10:0] req_addr, sram_addr;
  logic [31:0] req_wdata, rsp_rdata, sram_din, sram_dout;
  logic [3:0]  req_be, sram_write_en;

  // Instance 2: WR_CYC=3, SENSE_CYC=4, LANES=2, LANE_W=8
  logic        v2, rr2, we2, rv2, rdy2, sse2;
  logic [10:0] a2, sa2;
  logic [15:0] wd2, rd2, sd2, sdo2;
  logic [1:0]  be2, swe2;

  sram_lane_seq u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_write_en(sram_write_en),
    .sram_sense_en(sram_sense_en), .sram_dout(sram_dout)
  );

  sram_lane_seq #(.ADDR_W(11), .LANES(2), .LANE_W(8), .WR_CYC(3), .SENSE_CYC(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(v2), .req_ready(rr2), .req_we(we2),
    .req_addr(a2), .req_wdata(wd2), .req_be(be2),
    .rsp_valid(rv2), .rsp_ready(rdy2), .rsp_rdata(rd2),
    .sram_addr(sa2), .sram_din(sd2), .sram_write_en(swe2),
    .sram_sense_en(sse2), .sram_dout(sdo2)
  );

  logic [31:0] mem1 [0:2047];
  logic [31:0] ref1 [0:2047];
  logic [15:0] mem2 [0:2047];
  logic [15:0] ref2 [0:2047];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = '0; ref1[i] = '0; mem2[i] = '0; ref2[i] = '0;
    end
  end

  // Macro models: write lanes on a high write_en, latch read data while sense_en is low.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (sram_write_en[i]) mem1[sram_addr][i*8 +: 8] <= sram_din[i*8 +: 8];
    if (!sram_sense_en) sram_dout <= mem1[sram_addr];
    for (int i = 0; i < 2; i++)
      if (swe2[i]) mem2[sa2][i*8 +: 8] <= sd2[i*8 +: 8];
    if (!sse2) sdo2 <= mem2[sa2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of instance 1: one outstanding transaction, timed by its age in cycles.
  logic        m_busy, m_we;
  logic [3:0]  m_be;
  logic [10:0] m_addr;
  logic [31:0] m_din, m_pend, m_rdata;
  int          m_age;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_we <= 1'b0; m_be <= '0; m_age <= 0;
      m_addr <= '0; m_din <= '0; m_rdata <= '0; m_pend <= '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_addr <= req_addr; m_din <= req_wdata; m_be <= req_be; m_we <= req_we; m_age <= 0;
        if (req_we) begin
          for (int i = 0; i < 4; i++)
            if (req_be[i]) ref1[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
          m_busy <= (req_be != 4'd0);
        end else begin
          m_busy <= 1'b1;
          m_pend <= ref1[req_addr];
        end
      end
    end else begin
      m_age <= m_age + 1;
      if (m_we && m_age == WC1) m_busy <= 1'b0;
      if (!m_we && m_age == SC1) m_rdata <= m_pend;
      if (!m_we && m_age >= SC1 + 1 && rsp_ready) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("req_ready", 64'(req_ready), 64'(!m_busy));
    check("write_en", 64'(sram_write_en), 64'((m_busy && m_we && m_age < WC1) ? m_be : 4'd0));
    check("sense_en", 64'(sram_sense_en), 64'(!(m_busy && !m_we && m_age < SC1)));
    check("rsp_valid", 64'(rsp_valid), 64'(m_busy && !m_we && m_age >= SC1 + 1));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    check("sram_addr", 64'(sram_addr), 64'(m_addr));
    check("sram_din", 64'(sram_din), 64'(m_din));
    check("overlap1", 64'((sram_write_en != 4'd0) && !sram_sense_en), 64'd0);
    check("overlap2", 64'((swe2 != 2'd0) && !sse2), 64'd0);
  end

  int we_n, se_n, lat, idle_k;

  // Starting at the negedge after an accept, count strobe cycles, response latency and return to IDLE.
  task automatic measure(input bit sel);
    we_n = 0; se_n = 0; lat = 0; idle_k = 0;
    for (int k = 1; k <= 60; k++) begin
      if (sel ? (swe2 != 2'd0) : (sram_write_en != 4'd0)) we_n++;
      if (!(sel ? sse2 : sram_sense_en)) se_n++;
      if ((sel ? rv2 : rsp_valid) && lat == 0) lat = k - 1;
      if (sel ? rr2 : req_ready) begin
        idle_k = k;
        break;
      end
      @(negedge clk);
    end
    check("idle_reached", 64'(idle_k != 0), 64'd1);
  endtask

  task automatic send1(input bit we, input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = b;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept1", 64'(n < 100), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 11'($urandom);
    req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  task automatic send2(input bit we, input logic [10:0] a, input logic [15:0] d, input logic [1:0] b);
    int n;
    n = 0;
    v2 = 1'b1; we2 = we; a2 = a; wd2 = d; be2 = b;
    while (!rr2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept2", 64'(n < 100), 64'd1);
    @(negedge clk);
    v2 = 1'b0; we2 = 1'($urandom); a2 = 11'($urandom); wd2 = 16'($urandom); be2 = 2'($urandom);
  endtask

  logic [10:0] t_a;
  logic [15:0] t_d;
  logic [1:0]  t_b;
  int          n_wait;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    v2 = 1'b0; we2 = 1'b0; a2 = '0; wd2 = '0; be2 = '0; rdy2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_sense", 64'(sram_sense_en), 64'd1);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1'b0;

    // Full-word write then read at defaults.
    send1(1'b1, 11'h2A5, 32'hDEADBEEF, 4'hF);
    measure(1'b0);
    check("wr_pulse_len", 64'(we_n), 64'd1);
    check("wr_throughput", 64'(idle_k), 64'd3);
    send1(1'b0, 11'h2A5, 32'h0, 4'h0);
    measure(1'b0);
    check("rd_sense_len", 64'(se_n), 64'd1);
    check("rd_latency", 64'(lat), 64'd2);
    check("rd_data", 64'(rsp_rdata), 64'hDEADBEEF);

    // Byte enables, and a write with no lanes enabled.
    send1(1'b1, 11'h010, 32'h11223344, 4'hF);
    measure(1'b0);
    send1(1'b1, 11'h010, 32'hAABBCCDD, 4'b0101);
    measure(1'b0);
    send1(1'b1, 11'h010, 32'h55555555, 4'b0000);
    measure(1'b0);
    check("be0_no_pulse", 64'(we_n), 64'd0);
    check("be0_idle", 64'(idle_k), 64'd1);
    send1(1'b0, 11'h010, 32'h0, 4'h0);
    measure(1'b0);
    check("be_merge", 64'(rsp_rdata), 64'h11BB33DD);

    // Backpressure with a second request waiting.
    rsp_ready = 1'b0;
    send1(1'b0, 11'h2A5, 32'h0, 4'h0);
    n_wait = 0;
    while (!rsp_valid && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h3FF; req_wdata = 32'h01020304; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);
      check("bp_ready_low", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", 64'(req_ready), 64'd1);
    check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("bp_second_accept", 64'(req_ready), 64'd0);
    check("bp_second_addr", 64'(sram_addr), 64'h3FF);
    check("bp_second_we", 64'(sram_write_en), 64'hF);
    req_valid = 1'b0;
    measure(1'b0);

    // Reset while the read is sensing.
    send1(1'b0, 11'h3FF, 32'h0, 4'h0);
    check("in_sense", 64'(sram_sense_en), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_sense", 64'(sram_sense_en), 64'd1);
    check("abort_we", 64'(sram_write_en), 64'd0);
    check("abort_rsp", 64'(rsp_valid), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic on instance 1 against the cycle model.
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 11'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Instance 2: wide pulses and random write/read pairs against a scoreboard.
    for (int p = 0; p < 100; p++) begin
      t_a = 11'($urandom);
      t_d = 16'($urandom);
      t_b = 2'($urandom_range(1, 3));
      send2(1'b1, t_a, t_d, t_b);
      measure(1'b1);
      check("w2_pulse_len", 64'(we_n), 64'd3);
      check("w2_throughput", 64'(idle_k), 64'd5);
      for (int i = 0; i < 2; i++)
        if (t_b[i]) ref2[t_a][i*8 +: 8] = t_d[i*8 +: 8];
      send2(1'b0, t_a, 16'h0, 2'b00);
      measure(1'b1);
      check("r2_sense_len", 64'(se_n), 64'd4);
      check("r2_latency", 64'(lat), 64'd5);
      check("r2_data", 64'(rd2), 64'(ref2[t_a]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_lane_seq.md
Name: sram_lane_seq

Overview:
- Parametrised request sequencer in front of LANES compiled SRAM macros (e.g. sram_4kb_256x128x8), each LANE_W bits wide and sharing one address bus.
- Converts a valid/ready read/write request port into the macro pin protocol: write_en active high, sense_en active low, with address and data held stable for the whole operation.
- Adds what bare macro access lacks: per-lane byte-enable writes, programmable write and sense pulse lengths, write recovery, and a response handshake with backpressure.

Parameters:
- ADDR_W, 11, macro address width.
- LANES, 4, number of macros in parallel; data width = LANES*LANE_W.
- LANE_W, 8, bits per macro.
- WR_CYC, 1, cycles write_en is held high (1..15).
- SENSE_CYC, 1, cycles sense_en is held low (1..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  LANES*LANE_W  write data; lane i = bits [i*LANE_W +: LANE_W].
- req_be  in  LANES  per-lane write enable.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  LANES*LANE_W  captured read data.
- sram_addr  out  ADDR_W  shared macro address.
- sram_din  out  LANES*LANE_W  macro write data.
- sram_write_en  out  LANES  per-macro write strobe, active high.
- sram_sense_en  out  1  shared sense strobe, active low.
- sram_dout  in  LANES*LANE_W  macro read data.

Behaviour:
- Reset (sync, high), on the next edge:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - sram_addr=0, sram_din=0, sram_write_en=0, sram_sense_en=1.
- Reset mid-operation aborts at that edge. A write interrupted this way leaves the target word undefined; no response is produced.
- Accept condition: req_valid && req_ready at a posedge. At that edge, addr, wdata and be are registered into sram_addr, sram_din and a be register. They stay constant until the state returns to IDLE.
- Cycle counter: 4-bit, loaded at each state entry.
- State IDLE: strobes inactive.
  - Accept write with be!=0 -> WRITE.
  - Accept write with be==0 -> IDLE. No strobe is issued and no response is produced.
  - Accept read -> SENSE.
- State WRITE: sram_write_en=be_reg for WR_CYC cycles -> RECOV.
- State RECOV: write_en=0 for 1 cycle, so the address is stable across the write_en falling edge -> IDLE.
  - Write occupancy = WR_CYC+1 cycles after accept; back-to-back write throughput = WR_CYC+2 cycles.
- State SENSE: sram_sense_en=0 for SENSE_CYC cycles -> CAPT.
- State CAPT: sram_sense_en=1.
  - At the end edge, rsp_rdata<=sram_dout for all lanes (be is ignored on reads) and rsp_valid<=1 -> RESP.
- State RESP: rsp_valid=1 and rsp_rdata held stable until rsp_valid && rsp_ready.
  - At that edge, rsp_valid<=0 and state -> IDLE.
  - rsp_ready high on the cycle rsp_valid first rises completes immediately.
- Read latency: rsp_valid rises SENSE_CYC+1 cycles after the accept edge.
- Invariants:
  - sram_write_en is never nonzero while sram_sense_en==0.
  - write_en and sense_en are never both active.
  - Exactly one outstanding request.
  - req_ready=0 outside IDLE.
  - req_* inputs are ignored while req_ready=0.
- Address wrap is not applicable: the full ADDR_W range is valid and there is no auto-increment.
- Undefined inputs (X) on req_* while req_valid=0 must not propagate to state.

Test Plan:
- Reset: assert reset 2 cycles mid-read (in SENSE) -> next edge sense_en=1, write_en=0, rsp_valid=0, req_ready=1; no response emitted.
- Full write then read, defaults: write addr 0x2A5, data 0xDEADBEEF, be=4'hF -> write_en=4'hF for exactly 1 cycle, then 1 recovery cycle. Read 0x2A5 -> sense_en low 1 cycle; rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF.
- Byte enable: preload 0x11223344 at 0x010, write 0xAABBCCDD with be=4'b0101 -> readback 0x11BB33DD. A write with be=0 produces no write_en pulse and returns to IDLE in 1 cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_rdata stable, req_ready=0 throughout. Raise rsp_ready -> IDLE next cycle; a pending second request is accepted then.
- Parametrised pulses: WR_CYC=3, SENSE_CYC=4, LANES=2 -> write_en high exactly 3 cycles; sense_en low exactly 4 cycles; read latency 5 cycles; 100 random addr/data write-read pairs all match a scoreboard.
- Protocol checker: assertions run across all tests -> write_en and !sense_en never overlap; sram_addr/sram_din constant from accept until IDLE.
